// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: op codes, FSM state
// encoding and op-code classification helpers.
package alu_op_sequencer_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_CAPTURE,
    S_DONE
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // ADD..ROL form a contiguous range; the remaining legal codes are sparse.
  function automatic logic is_legal_op(input logic [4:0] op);
    return ((op >= OP_ADD) && (op <= OP_ROL)) || is_muldiv(op) ||
           (op == OP_NEG) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and result signals of the ALU operation sequencer.
interface alu_op_sequencer_if
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W = 32
);
  // Handshake: start is honoured only while busy=0 (never queued); the
  // request is consumed on that edge, and completion is a one-cycle done
  // pulse with illegal/hi_we/lo_we qualified by done.
  logic                start;
  logic [4:0]          op;
  logic [DATA_W-1:0]   src_a;
  logic [DATA_W-1:0]   src_b;
  logic                busy;
  logic                done;
  logic                illegal;
  logic [DATA_W-1:0]   y_out;
  logic [DATA_W-1:0]   b_out;
  logic [4:0]          alu_ctrl;
  logic                alu_in;
  logic [2*DATA_W-1:0] z_in;
  logic [DATA_W-1:0]   zhi;
  logic [DATA_W-1:0]   zlo;
  logic                hi_we;
  logic                lo_we;
  logic [DATA_W-1:0]   result;
  state_t              dbg_state;

  modport master (
    output start, op, src_a, src_b, z_in,
    input  busy, done, illegal, y_out, b_out, alu_ctrl, alu_in,
           zhi, zlo, hi_we, lo_we, result, dbg_state
  );

  modport slave (
    input  start, op, src_a, src_b, z_in,
    output busy, done, illegal, y_out, b_out, alu_ctrl, alu_in,
           zhi, zlo, hi_we, lo_we, result, dbg_state
  );
endinterface

// File: rtl/alu_wait_counter.sv
// Loadable down-counter timing the ALU settle window; term flags count==1.
module alu_wait_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             term_o
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = (count_q == CNT_W'(1));
endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle control stage around the datapath ALU: registers operands,
// strobes alu_in for the settle window, captures Z and pulses done.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SIMPLE_WAIT = 1,
  parameter int MULDIV_WAIT = 4
) (
  input logic              clock,
  input logic              clear,
  alu_op_sequencer_if.slave bus
);
  localparam int MAX_WAIT = (MULDIV_WAIT > SIMPLE_WAIT) ? MULDIV_WAIT : SIMPLE_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] SIMPLE_LD = CNT_W'(SIMPLE_WAIT);
  localparam logic [CNT_W-1:0] MULDIV_LD = CNT_W'(MULDIV_WAIT);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] y_q, b_q, zhi_q, zlo_q;
  logic [4:0]        ctrl_q;
  logic              ill_q, ill_d;
  logic              alu_in_q;
  logic              accept, capture, cnt_dec, cnt_term;
  logic [CNT_W-1:0]  cnt_val;
  logic              done_w;

  alu_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clock      (clock),
    .clear      (clear),
    .load_i     (accept),
    .load_val_i (is_muldiv(bus.op) ? MULDIV_LD : SIMPLE_LD),
    .dec_i      (cnt_dec),
    .count_o    (cnt_val),
    .term_o     (cnt_term)
  );

  always_comb begin
    state_d = state_q;
    ill_d   = ill_q;
    accept  = 1'b0;
    capture = 1'b0;
    cnt_dec = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (is_legal_op(bus.op)) begin
            accept  = 1'b1;
            ill_d   = 1'b0;
            state_d = S_LOAD;
          end else begin
            ill_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: state_d = S_EVAL;
      S_EVAL: begin
        if (cnt_term) state_d = S_CAPTURE;
        else          cnt_dec = 1'b1;
      end
      S_CAPTURE: begin
        capture = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // alu_in is decoded from the next state so it toggles cleanly on EVAL entry/exit.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= S_IDLE;
      y_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      zhi_q    <= '0;
      zlo_q    <= '0;
      ill_q    <= 1'b0;
      alu_in_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ill_q    <= ill_d;
      alu_in_q <= (state_d == S_EVAL);
      if (accept) begin
        y_q    <= bus.src_a;
        b_q    <= bus.src_b;
        ctrl_q <= bus.op;
      end
      if (capture) begin
        zhi_q <= bus.z_in[2*DATA_W-1:DATA_W];
        zlo_q <= bus.z_in[DATA_W-1:0];
      end
    end
  end

  assign done_w        = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_w;
  assign bus.illegal   = done_w && ill_q;
  assign bus.hi_we     = done_w && !ill_q && is_muldiv(ctrl_q);
  assign bus.lo_we     = done_w && !ill_q && is_muldiv(ctrl_q);
  assign bus.alu_in    = alu_in_q;
  assign bus.y_out     = y_q;
  assign bus.b_out     = b_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.zhi       = zhi_q;
  assign bus.zlo       = zlo_q;
  assign bus.result    = zlo_q;
  assign bus.dbg_state = state_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt_val;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer with a behavioural ALU in the loop.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] zhi;
    logic [W-1:0] zlo;
    logic         ill;
    logic         we;
    logic [15:0]  cyc;
    logic [7:0]   alu_cyc;
  } exp_t;

  logic clock = 1'b0;
  logic clear;
  logic [15:0] cyc = '0;
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int stray_we = 0;
  int alu_cnt = 0;
  logic [$bits(exp_t)-1:0] exp_q[$];

  alu_op_sequencer_if #(.DATA_W(W)) ifc ();

  alu_op_sequencer #(.DATA_W(W), .SIMPLE_WAIT(1), .MULDIV_WAIT(4)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (ifc)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 16'd1;

  // ---------------- ALU model in the loop ----------------
  function automatic logic [2*W-1:0] alu_model(input logic [4:0] ctrl,
                                               input logic [W-1:0] y,
                                               input logic [W-1:0] b);
    logic [4:0]     s;
    logic [2*W-1:0] yy;
    logic [2*W-1:0] r;
    s  = b[4:0];
    yy = {y, y};
    r  = '0;
    case (ctrl)
      OP_ADD:  r = {32'd0, y + b};
      OP_SUB:  r = {32'd0, y - b};
      OP_AND:  r = {32'd0, y & b};
      OP_OR:   r = {32'd0, y | b};
      OP_SHR:  r = {32'd0, y >> s};
      OP_SHRA: r = {32'd0, 32'($signed(y) >>> s)};
      OP_SHL:  r = {32'd0, y << s};
      OP_ROR:  begin yy = yy >> s; r = {32'd0, yy[W-1:0]}; end
      OP_ROL:  begin yy = yy << s; r = {32'd0, yy[2*W-1:W]}; end
      OP_MUL:  r = 64'($signed({{32{y[31]}}, y}) * $signed({{32{b[31]}}, b}));
      OP_DIV:  if (b != '0) r = {32'($signed(y) % $signed(b)), 32'($signed(y) / $signed(b))};
      OP_NEG:  r = {32'd0, -b};
      OP_NOT:  r = {32'd0, ~b};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb ifc.z_in = alu_model(ifc.alu_ctrl, ifc.y_out, ifc.b_out);

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic check_zeros(input string tag);
    check({tag, "_busy"},     64'(ifc.busy),     64'd0);
    check({tag, "_done"},     64'(ifc.done),     64'd0);
    check({tag, "_illegal"},  64'(ifc.illegal),  64'd0);
    check({tag, "_alu_in"},   64'(ifc.alu_in),   64'd0);
    check({tag, "_hi_we"},    64'(ifc.hi_we),    64'd0);
    check({tag, "_lo_we"},    64'(ifc.lo_we),    64'd0);
    check({tag, "_y_out"},    64'(ifc.y_out),    64'd0);
    check({tag, "_b_out"},    64'(ifc.b_out),    64'd0);
    check({tag, "_alu_ctrl"}, 64'(ifc.alu_ctrl), 64'd0);
    check({tag, "_zhi"},      64'(ifc.zhi),      64'd0);
    check({tag, "_zlo"},      64'(ifc.zlo),      64'd0);
    check({tag, "_result"},   64'(ifc.result),   64'd0);
    check({tag, "_state"},    64'(ifc.dbg_state), 64'(S_IDLE));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!clear) begin
      alu_cnt = 0;
    end else begin
      if (ifc.alu_in) alu_cnt++;
      if ((ifc.hi_we || ifc.lo_we) && !ifc.done) stray_we++;
      if (ifc.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected no pending request", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("zlo",      64'(ifc.zlo),     64'(e.zlo));
          check("zhi",      64'(ifc.zhi),     64'(e.zhi));
          check("result",   64'(ifc.result),  64'(e.zlo));
          check("illegal",  64'(ifc.illegal), 64'(e.ill));
          check("hi_we",    64'(ifc.hi_we),   64'(e.we));
          check("lo_we",    64'(ifc.lo_we),   64'(e.we));
          check("busy_in_done", 64'(ifc.busy), 64'd1);
          check("latency_cycle", 64'(cyc),    64'(e.cyc));
          check("alu_in_cycles", 64'(alu_cnt), 64'(e.alu_cyc));
        end
        alu_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [4:0] op_v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ezhi, input logic [W-1:0] ezlo,
                       input logic eill, input logic ewe, input int lat, input int wcyc);
    exp_t e;
    @(negedge clock);
    ifc.start = 1'b1;
    ifc.op    = op_v;
    ifc.src_a = a;
    ifc.src_b = b;
    @(posedge clock);
    #1;
    e.zhi     = ezhi;
    e.zlo     = ezlo;
    e.ill     = eill;
    e.we      = ewe;
    e.cyc     = cyc + 16'(lat) - 16'd1;
    e.alu_cyc = 8'(wcyc);
    exp_q.push_back(e);
    exp_done++;
    // Registered copies must be used; scramble the live inputs.
    ifc.start = 1'b0;
    ifc.op    = 5'($urandom_range(0, 31));
    ifc.src_a = $urandom();
    ifc.src_b = $urandom();
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (ifc.done) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done within 40 cycles, expected done", name);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ifc.start = 1'b0;
    ifc.op    = '0;
    ifc.src_a = '0;
    ifc.src_b = '0;
    clear     = 1'b1;
    #3 clear  = 1'b0;
    #1 check_zeros("reset");
    repeat (2) @(negedge clock);
    #2 clear = 1'b1;

    issue(OP_ADD, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0, 1'b0, 4, 1);
    wait_done("add");
    issue(5'b00000, 32'd1, 32'd2, 32'd0, 32'd12, 1'b1, 1'b0, 1, 0);
    wait_done("illegal0");
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, 7, 4);
    wait_done("mul");
    issue(5'b11111, 32'd3, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1, 0);
    wait_done("illegal31");
    issue(OP_DIV, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0, 1'b1, 7, 4);
    wait_done("div");
    issue(OP_NEG, 32'h1234, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4, 1);
    wait_done("neg");
    issue(OP_ROL, 32'h8000_0001, 32'd1, 32'd0, 32'd3, 1'b0, 1'b0, 4, 1);
    wait_done("rol");
    issue(5'b01100, 32'd9, 32'd9, 32'd0, 32'd3, 1'b1, 1'b0, 1, 0);
    wait_done("illegal12");

    // Start during EVAL of a MUL must be ignored; SUB follows back-to-back.
    issue(OP_MUL, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b1, 7, 4);
    @(negedge clock);
    @(negedge clock);
    check("busy_in_eval", 64'(ifc.busy), 64'd1);
    ifc.start = 1'b1;
    ifc.op    = OP_SUB;
    ifc.src_a = 32'd100;
    ifc.src_b = 32'd1;
    @(negedge clock);
    ifc.start = 1'b0;
    wait_done("mul_busy");
    issue(OP_SUB, 32'd9, 32'd4, 32'd0, 32'd5, 1'b0, 1'b0, 4, 1);
    wait_done("sub");

    // Reset during EVAL of a DIV aborts it.
    issue(OP_DIV, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0, 1'b1, 7, 4);
    repeat (3) @(negedge clock);
    check("state_before_abort", 64'(ifc.dbg_state), 64'(S_EVAL));
    #2 clear = 1'b0;
    #1 check_zeros("abort");
    void'(exp_q.pop_back());
    exp_done--;
    repeat (2) @(negedge clock);
    #2 clear = 1'b1;
    issue(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd2, 1'b0, 1'b0, 4, 1);
    wait_done("add_after_reset");

    repeat (5) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("done_count",    64'(done_cnt),     64'(exp_done));
    check("stray_we",      64'(stray_we),     64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at 100000, expected completion");
    $fatal(1);
  end
endmodule
